// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: shared state encoding and counter sizing for the bit-serial subtractor
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/fullsubtractor_sf.sv
// fullsubtractor_sf: gate-level one-bit full subtractor, diff = a - b - bin
module fullsubtractor_sf (
    output logic diff,
    output logic bout,
    input  logic a,
    input  logic b,
    input  logic bin
);

    logic t, na, nt, g1, g2;

    xor x1 (t, a, b);
    xor x2 (diff, t, bin);
    not n1 (na, a);
    and a1 (g1, na, b);
    not n2 (nt, t);
    and a2 (g2, nt, bin);
    or  o1 (bout, g1, g2);

endmodule

// File: rtl/serial_subtractor_sf.sv
// serial_subtractor_sf: LSB-first bit-serial a - b with start/busy/done handshake
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor_sf
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sa, sb;
    logic [WIDTH-2:0] res;
    logic             br, diff, bnext;
    logic [WIDTH-1:0] cat;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb, b_msb;
`endif

    assign cat = {diff, res};

    fullsubtractor_sf u_cell (
        .diff(diff),
        .bout(bnext),
        .a   (sa[0]),
        .b   (sb[0]),
        .bin (br)
    );

    // FSM, operand shifting, borrow chain and registered result/handshake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            sa    <= '0;
            sb    <= '0;
            res   <= '0;
            br    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            d     <= '0;
            bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= 1'b0;
            b_msb <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else if (start && state != RUN) begin
            state <= RUN;
            sa    <= a;
            sb    <= b;
            br    <= 1'b0;
            cnt   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
`endif
        end else if (state == RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            br  <= bnext;
            res <= cat[WIDTH-1:1];
            cnt <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
                state <= DONE;
                d     <= cat;
                bout  <= bnext;
                busy  <= 1'b0;
                done  <= 1'b1;
`ifdef SERIAL_SUB_OVF_EN
                ovf   <= (a_msb != b_msb) & (diff != a_msb);
`endif
            end
        end else begin
            state <= IDLE;
            done  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_serial_subtractor_sf.sv
// tb_serial_subtractor_sf: directed self-checking bench for serial_subtractor_sf (WIDTH=8)
module tb_serial_subtractor_sf;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       busy, done, bout;
    logic [7:0] d;
`ifdef SERIAL_SUB_OVF_EN
    logic       ovf;
`endif

    int checks = 0;
    int errors = 0;

    serial_subtractor_sf #(.WIDTH(8)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .start(start),
        .a    (a),
        .b    (b),
        .busy (busy),
        .done (done),
        .d    (d),
        .bout (bout)
`ifdef SERIAL_SUB_OVF_EN
        ,
        .ovf  (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [7:0] x, input logic [7:0] y);
        a = x;
        b = y;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!done && n < 20);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++;
        if ({busy, done, bout, d} !== 11'd0) begin
            errors++;
            $display("FAIL reset busy/done/bout/d got %b/%b/%b/%h want 0/0/0/00", busy, done, bout, d);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf got %b want 0", ovf);
        end
`endif
    endtask

    task automatic test_basic(input logic [7:0] x, input logic [7:0] y,
                              input logic [7:0] ed, input logic eb, input logic eo);
        int n;
        launch(x, y);
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL accept_%h_%h busy/done got %b/%b want 1/0", x, y, busy, done);
        end
        wait_done(n);
        checks++;
        if (n !== 8) begin
            errors++;
            $display("FAIL latency_%h_%h got %0d want 8", x, y, n);
        end
        checks++;
        if (d !== ed || bout !== eb || busy !== 1'b0) begin
            errors++;
            $display("FAIL result_%h_%h d/bout/busy got %h/%b/%b want %h/%b/0", x, y, d, bout, busy, ed, eb);
        end
`ifdef SERIAL_SUB_OVF_EN
        checks++;
        if (ovf !== eo) begin
            errors++;
            $display("FAIL ovf_%h_%h got %b want %b", x, y, ovf, eo);
        end
`else
        if (eo === 1'bx) $display("unexpected x");
`endif
        tick();
        checks++;
        if (done !== 1'b0 || d !== ed || bout !== eb) begin
            errors++;
            $display("FAIL hold_%h_%h done/d/bout got %b/%h/%b want 0/%h/%b", x, y, done, d, bout, ed, eb);
        end
    endtask

    task automatic test_start_held();
        logic [7:0] prev;
        prev = d;
        a = 8'h25;
        b = 8'h13;
        start = 1'b1;
        tick();
        for (int i = 1; i < 8; i++) begin
            a = 8'(i * 37);
            b = 8'(i * 91);
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b1 || d !== prev) begin
                errors++;
                $display("FAIL held_run_%0d done/busy/d got %b/%b/%h want 0/1/%h", i, done, busy, d, prev);
            end
        end
        start = 1'b0;
        tick();
        checks++;
        if (done !== 1'b1 || d !== 8'h12 || bout !== 1'b0) begin
            errors++;
            $display("FAIL held_result done/d/bout got %b/%h/%b want 1/12/0", done, d, bout);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        launch(8'h25, 8'h13);
        wait_done(n);
        a = 8'h13;
        b = 8'h25;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || d !== 8'h12) begin
            errors++;
            $display("FAIL b2b_accept busy/done/d got %b/%b/%h want 1/0/12", busy, done, d);
        end
        wait_done(n);
        checks++;
        if (n !== 8 || d !== 8'hEE || bout !== 1'b1) begin
            errors++;
            $display("FAIL b2b_result n/d/bout got %0d/%h/%b want 8/ee/1", n, d, bout);
        end
        tick();
    endtask

    task automatic test_abort();
        int seen;
        launch(8'h25, 8'h13);
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if ({busy, done, bout, d} !== 11'd0) begin
            errors++;
            $display("FAIL abort_state busy/done/bout/d got %b/%b/%b/%h want 0/0/0/00", busy, done, bout, d);
        end
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_quiet active_cycles got %0d want 0", seen);
        end
        test_basic(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
    endtask

    task automatic test_equal_busy();
        int n;
        launch(8'hAA, 8'hAA);
        n = 0;
        while (busy && n < 20) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 8 || done !== 1'b1 || d !== 8'h00 || bout !== 1'b0) begin
            errors++;
            $display("FAIL equal busy_cycles/done/d/bout got %0d/%b/%h/%b want 8/1/00/0", n, done, d, bout);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic(8'h25, 8'h13, 8'h12, 1'b0, 1'b0);
        test_basic(8'h13, 8'h25, 8'hEE, 1'b1, 1'b0);
        test_basic(8'h00, 8'h01, 8'hFF, 1'b1, 1'b0);
        test_basic(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
        test_basic(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1);
        test_basic(8'h25, 8'h13, 8'h12, 1'b0, 1'b0);
        test_start_held();
        test_back_to_back();
        test_abort();
        test_equal_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
